read_return_tagger: RTL and testbench

- Sits directly downstream of the bank-level backend controller.
- Records the row/col address of every read command the backend accepts, in acceptance order.
- Pairs each returned read beat (read_data/read_data_valid) with the oldest outstanding address and buffers the tagged result for the frontend consumer.
- Drives backend_controller_ren to throttle read returns against its own buffer space.

---
 rtl/read_return_tagger.sv | 152 +++++++++++++++
 tb/tb_read_return_tagger.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_return_tagger.sv
// Tags each returned read beat with the row/col of the oldest outstanding read and buffers it FWFT.
// Defining READ_RETURN_STATS_EN adds returned-beat and peak-outstanding statistics outputs.
module read_return_tagger #(
   parameter int DATA_W     = 1024,
   parameter int ROW_W      = 16,
   parameter int COL_W      = 4,
   parameter int TAG_DEPTH  = 16,
   parameter int DATA_DEPTH = 8,
   parameter int REN_THRESH = 2
) (
   input  logic                             clk,
   input  logic                             power_on_rst,
   input  logic                             cmd_valid,
   input  logic                             cmd_accept,
   input  logic                             cmd_is_read,
   input  logic [ROW_W-1:0]                 cmd_row,
   input  logic [COL_W-1:0]                 cmd_col,
   output logic                             tag_full,
   output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding_cnt,
   input  logic [DATA_W-1:0]                read_data,
   input  logic                             read_data_valid,
   output logic                             backend_controller_ren,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_W-1:0]                out_data,
   output logic [ROW_W-1:0]                 out_row,
   output logic [COL_W-1:0]                 out_col,
   output logic                             err_tag_ovf,
   output logic                             err_orphan,
   output logic                             err_data_ovf
`ifdef READ_RETURN_STATS_EN
   ,
   output logic [31:0]                      stat_rd_returned,
   output logic [$clog2(TAG_DEPTH+1)-1:0]   stat_max_outstanding
`endif
);

   localparam int TPTR_W = $clog2(TAG_DEPTH);
   localparam int TCNT_W = $clog2(TAG_DEPTH + 1);
   localparam int DPTR_W = $clog2(DATA_DEPTH);
   localparam int DCNT_W = DPTR_W + 1;
   localparam int ADDR_W = ROW_W + COL_W;
   localparam int ENT_W  = DATA_W + ADDR_W;

   logic [ADDR_W-1:0] tag_mem_r [TAG_DEPTH];
   logic [TPTR_W-1:0] tag_wr_ptr_r;
   logic [TPTR_W-1:0] tag_rd_ptr_r;
   logic [TCNT_W-1:0] tag_cnt_r;

   logic [ENT_W-1:0]  data_mem_r [DATA_DEPTH];
   logic [DPTR_W-1:0] data_wr_ptr_r;
   logic [DPTR_W-1:0] data_rd_ptr_r;
   logic [DCNT_W-1:0] data_cnt_r;

   logic              rd_hs_s;
   logic              tag_push_s;
   logic              tag_pop_s;
   logic              data_full_s;
   logic              data_push_s;
   logic              out_pop_s;
   logic [TCNT_W-1:0] tag_cnt_next_s;
   logic [DCNT_W-1:0] data_cnt_next_s;
   logic [DCNT_W-1:0] data_free_s;
   logic [ENT_W-1:0]  head_s;

   // A pop only ever sees registered tag occupancy, so a same-cycle push cannot be paired.
   assign rd_hs_s         = cmd_valid && cmd_accept && cmd_is_read;
   assign tag_full        = (tag_cnt_r == TCNT_W'(TAG_DEPTH));
   assign tag_push_s      = rd_hs_s && !tag_full;
   assign tag_pop_s       = read_data_valid && (tag_cnt_r != '0);
   assign out_valid       = (data_cnt_r != '0);
   assign out_pop_s       = out_valid && out_ready;
   assign data_full_s     = (data_cnt_r == DCNT_W'(DATA_DEPTH));
   assign data_push_s     = tag_pop_s && (!data_full_s || out_pop_s);
   assign tag_cnt_next_s  = tag_cnt_r + TCNT_W'(tag_push_s) - TCNT_W'(tag_pop_s);
   assign data_cnt_next_s = data_cnt_r + DCNT_W'(data_push_s) - DCNT_W'(out_pop_s);
   assign data_free_s     = DCNT_W'(DATA_DEPTH) - data_cnt_next_s;
   assign outstanding_cnt = tag_cnt_r;

   // Empty buffer presents zeros so the reset view of out_* is all-zero.
   assign head_s   = data_mem_r[data_rd_ptr_r];
   assign out_data = out_valid ? head_s[ENT_W-1 -: DATA_W]      : '0;
   assign out_row  = out_valid ? head_s[ADDR_W-1 -: ROW_W]      : '0;
   assign out_col  = out_valid ? head_s[COL_W-1:0]              : '0;

   // Tag FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge power_on_rst) begin
      if (power_on_rst) begin
         tag_wr_ptr_r <= '0;
         tag_rd_ptr_r <= '0;
         tag_cnt_r    <= '0;
      end else begin
         if (tag_push_s) tag_wr_ptr_r <= tag_wr_ptr_r + TPTR_W'(1);
         if (tag_pop_s)  tag_rd_ptr_r <= tag_rd_ptr_r + TPTR_W'(1);
         tag_cnt_r <= tag_cnt_next_s;
      end
   end

   // Tag storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (tag_push_s) tag_mem_r[tag_wr_ptr_r] <= {cmd_row, cmd_col};
   end

   // Return buffer pointers and occupancy.
   always_ff @(posedge clk or posedge power_on_rst) begin
      if (power_on_rst) begin
         data_wr_ptr_r <= '0;
         data_rd_ptr_r <= '0;
         data_cnt_r    <= '0;
      end else begin
         if (data_push_s) data_wr_ptr_r <= data_wr_ptr_r + DPTR_W'(1);
         if (out_pop_s)   data_rd_ptr_r <= data_rd_ptr_r + DPTR_W'(1);
         data_cnt_r <= data_cnt_next_s;
      end
   end

   // Return buffer storage: {data, row, col} of the paired tag.
   always_ff @(posedge clk) begin
      if (data_push_s) data_mem_r[data_wr_ptr_r] <= {read_data, tag_mem_r[tag_rd_ptr_r]};
   end

   // Sticky error flags and the registered return-enable.
   always_ff @(posedge clk or posedge power_on_rst) begin
      if (power_on_rst) begin
         err_tag_ovf            <= 1'b0;
         err_orphan             <= 1'b0;
         err_data_ovf           <= 1'b0;
         backend_controller_ren <= 1'b0;
      end else begin
         if (rd_hs_s && tag_full)                   err_tag_ovf  <= 1'b1;
         if (read_data_valid && (tag_cnt_r == '0))  err_orphan   <= 1'b1;
         if (tag_pop_s && !data_push_s)             err_data_ovf <= 1'b1;
         backend_controller_ren <= (data_free_s >= DCNT_W'(REN_THRESH));
      end
   end

`ifdef READ_RETURN_STATS_EN
   // Saturating return counter and peak tag occupancy.
   always_ff @(posedge clk or posedge power_on_rst) begin
      if (power_on_rst) begin
         stat_rd_returned     <= 32'd0;
         stat_max_outstanding <= '0;
      end else begin
         if (data_push_s && (stat_rd_returned != 32'hFFFF_FFFF))
            stat_rd_returned <= stat_rd_returned + 32'd1;
         if (tag_cnt_next_s > stat_max_outstanding)
            stat_max_outstanding <= tag_cnt_next_s;
      end
   end
`endif

endmodule

// File: tb/tb_read_return_tagger.sv
// Self-checking bench for read_return_tagger: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_read_return_tagger;

   localparam int DATA_W     = 1024;
   localparam int ROW_W      = 16;
   localparam int COL_W      = 4;
   localparam int TAG_DEPTH  = 16;
   localparam int DATA_DEPTH = 8;
   localparam int REN_THRESH = 2;
   localparam int CNT_W      = $clog2(TAG_DEPTH + 1);

   logic              clk = 1'b0;
   logic              power_on_rst;
   logic              cmd_valid, cmd_accept, cmd_is_read;
   logic [ROW_W-1:0]  cmd_row;
   logic [COL_W-1:0]  cmd_col;
   logic              tag_full;
   logic [CNT_W-1:0]  outstanding_cnt;
   logic [DATA_W-1:0] read_data;
   logic              read_data_valid;
   logic              backend_controller_ren;
   logic              out_valid, out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ROW_W-1:0]  out_row;
   logic [COL_W-1:0]  out_col;
   logic              err_tag_ovf, err_orphan, err_data_ovf;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } addr_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
   } ent_t;

   addr_t tag_q[$];
   ent_t  ret_q[$];
   bit    m_tag_ovf, m_orphan, m_data_ovf, m_ren;

   always #5 clk = ~clk;

   read_return_tagger #(
      .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W),
      .TAG_DEPTH(TAG_DEPTH), .DATA_DEPTH(DATA_DEPTH), .REN_THRESH(REN_THRESH)
   ) dut (
      .clk(clk), .power_on_rst(power_on_rst),
      .cmd_valid(cmd_valid), .cmd_accept(cmd_accept), .cmd_is_read(cmd_is_read),
      .cmd_row(cmd_row), .cmd_col(cmd_col),
      .tag_full(tag_full), .outstanding_cnt(outstanding_cnt),
      .read_data(read_data), .read_data_valid(read_data_valid),
      .backend_controller_ren(backend_controller_ren),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_col(out_col),
      .err_tag_ovf(err_tag_ovf), .err_orphan(err_orphan), .err_data_ovf(err_data_ovf)
   );

   task automatic model_reset();
      tag_q.delete();
      ret_q.delete();
      m_tag_ovf = 1'b0; m_orphan = 1'b0; m_data_ovf = 1'b0; m_ren = 1'b0;
   endtask

   // One clock of the reference: all decisions use the pre-edge occupancies.
   task automatic model_step();
      int    tsz;
      int    rsz;
      bit    opop;
      addr_t a;
      ent_t  e;
      tsz  = tag_q.size();
      rsz  = ret_q.size();
      opop = (rsz > 0) && out_ready;
      if (opop) e = ret_q.pop_front();
      if (read_data_valid) begin
         if (tsz == 0) m_orphan = 1'b1;
         else begin
            a = tag_q.pop_front();
            if (rsz < DATA_DEPTH || opop) begin
               e.data = read_data; e.row = a.row; e.col = a.col;
               ret_q.push_back(e);
            end else m_data_ovf = 1'b1;
         end
      end
      if (cmd_valid && cmd_accept && cmd_is_read) begin
         if (tsz == TAG_DEPTH) m_tag_ovf = 1'b1;
         else begin
            a.row = cmd_row; a.col = cmd_col;
            tag_q.push_back(a);
         end
      end
      m_ren = (DATA_DEPTH - ret_q.size()) >= REN_THRESH;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0; cmd_accept = 1'b0; cmd_is_read = 1'b0;
      cmd_row = '0; cmd_col = '0;
      read_data_valid = 1'b0; read_data = '0;
   endtask

   task automatic send_read(input int row, input int col);
      cmd_valid = 1'b1; cmd_accept = 1'b1; cmd_is_read = 1'b1;
      cmd_row = ROW_W'(row); cmd_col = COL_W'(col);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, backend_controller_ren, tag_full, err_tag_ovf, err_orphan, err_data_ovf} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b required 000000",
                  {out_valid, backend_controller_ren, tag_full, err_tag_ovf, err_orphan, err_data_ovf});
      end
      vectors++;
      if (outstanding_cnt !== '0 || out_row !== '0 || out_col !== '0 || out_data[63:0] !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_values: cnt=%0d row=%0h col=%0h data=%0h required all 0",
                  outstanding_cnt, out_row, out_col, out_data[63:0]);
      end
      power_on_rst = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         if (i >= 1) begin
            vectors++;
            if (backend_controller_ren !== 1'b1) begin
               miscompares++;
               $display("FAIL idle_ren cycle %0d: got %b required 1", i, backend_controller_ren);
            end
         end
         vectors++;
         if (out_valid !== 1'b0 || outstanding_cnt !== '0 || {err_tag_ovf, err_orphan, err_data_ovf} !== 3'b0) begin
            miscompares++;
            $display("FAIL idle_state cycle %0d: valid=%b cnt=%0d errs=%b required 0",
                     i, out_valid, outstanding_cnt, {err_tag_ovf, err_orphan, err_data_ovf});
         end
      end
   endtask

   task automatic test_in_order();
      int k;
      int guard;
      k = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_read(0, i);
         step();
         vectors++;
         if (outstanding_cnt !== CNT_W'(i + 1)) begin
            miscompares++;
            $display("FAIL inorder_cnt %0d: got %0d required %0d", i, outstanding_cnt, i + 1);
         end
      end
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         read_data_valid = 1'b1;
         read_data = DATA_W'(i);
         step();
         if (out_valid) begin
            vectors++;
            if (out_row !== '0 || out_col !== COL_W'(k) || out_data !== DATA_W'(k)) begin
               miscompares++;
               $display("FAIL inorder_entry %0d: row=%0h col=%0h data=%0h required 0/%0h/%0h",
                        k, out_row, out_col, out_data[63:0], k, k);
            end
            k++;
         end
      end
      idle_inputs();
      guard = 0;
      while (k < 16 && guard < 20) begin
         step();
         if (out_valid) k++;
         guard++;
      end
      step();
      vectors++;
      if (k != 16 || outstanding_cnt !== '0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL inorder_done: entries=%0d cnt=%0d valid=%b required 16/0/0", k, outstanding_cnt, out_valid);
      end
   endtask

   task automatic test_tag_ovf();
      int n;
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send_read(1, i % 16);
         step();
         vectors++;
         if (tag_full !== (i >= 15)) begin
            miscompares++;
            $display("FAIL tag_full %0d: got %b required %b", i, tag_full, (i >= 15));
         end
      end
      idle_inputs();
      vectors++;
      if (err_tag_ovf !== 1'b1 || outstanding_cnt !== CNT_W'(16)) begin
         miscompares++;
         $display("FAIL tag_ovf: err=%b cnt=%0d required 1/16", err_tag_ovf, outstanding_cnt);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         read_data_valid = (i < 17);
         read_data = DATA_W'(100 + i);
         step();
         if (out_valid) begin
            vectors++;
            if (out_row !== ROW_W'(1) || out_col !== COL_W'(n) || out_data !== DATA_W'(100 + n)) begin
               miscompares++;
               $display("FAIL tag_ovf_drain %0d: row=%0h col=%0h data=%0h required 1/%0h/%0h",
                        n, out_row, out_col, out_data[63:0], n, 100 + n);
            end
            n++;
         end
      end
      idle_inputs();
      step();
      vectors++;
      if (n != 16 || out_valid !== 1'b0 || outstanding_cnt !== '0) begin
         miscompares++;
         $display("FAIL tag_ovf_count: entries=%0d valid=%b cnt=%0d required 16/0/0", n, out_valid, outstanding_cnt);
      end
   endtask

   task automatic test_data_ovf();
      int n;
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_read(2, i);
         step();
      end
      idle_inputs();
      for (int k = 1; k <= 9; k++) begin
         read_data_valid = 1'b1;
         read_data = DATA_W'(200 + k - 1);
         step();
         vectors++;
         if (backend_controller_ren !== m_ren || backend_controller_ren !== (k <= 6)) begin
            miscompares++;
            $display("FAIL data_ren beat %0d: got %b required %b", k, backend_controller_ren, (k <= 6));
         end
         vectors++;
         if (err_data_ovf !== (k == 9)) begin
            miscompares++;
            $display("FAIL data_ovf beat %0d: got %b required %b", k, err_data_ovf, (k == 9));
         end
      end
      idle_inputs();
      out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) begin
            vectors++;
            if (out_row !== ROW_W'(2) || out_col !== COL_W'(n) || out_data !== DATA_W'(200 + n)) begin
               miscompares++;
               $display("FAIL data_drain %0d: row=%0h col=%0h data=%0h required 2/%0h/%0h",
                        n, out_row, out_col, out_data[63:0], n, 200 + n);
            end
            n++;
         end
         step();
      end
      vectors++;
      if (n != 8 || out_valid !== 1'b0 || outstanding_cnt !== '0 || backend_controller_ren !== 1'b1) begin
         miscompares++;
         $display("FAIL data_drain_count: entries=%0d valid=%b cnt=%0d ren=%b required 8/0/0/1",
                  n, out_valid, outstanding_cnt, backend_controller_ren);
      end
   endtask

   task automatic test_orphan();
      out_ready = 1'b0;
      idle_inputs();
      read_data_valid = 1'b1;
      read_data = DATA_W'(16'hDEAD);
      step();
      vectors++;
      if (err_orphan !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL orphan: err=%b valid=%b required 1/0", err_orphan, out_valid);
      end
      idle_inputs();
      step();
      send_read(3, 5);
      step();
      idle_inputs();
      read_data_valid = 1'b1;
      read_data = DATA_W'(16'h05A5);
      step();
      idle_inputs();
      vectors++;
      if (out_valid !== 1'b1 || out_row !== ROW_W'(3) || out_col !== COL_W'(5) || out_data !== DATA_W'(16'h05A5)) begin
         miscompares++;
         $display("FAIL orphan_next: valid=%b row=%0h col=%0h data=%0h required 1/3/5/5a5",
                  out_valid, out_row, out_col, out_data[63:0]);
      end
      out_ready = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b0 || outstanding_cnt !== '0) begin
         miscompares++;
         $display("FAIL orphan_drain: valid=%b cnt=%0d required 0/0", out_valid, outstanding_cnt);
      end
   endtask

   task automatic test_same_cycle_and_reset();
      out_ready = 1'b0;
      send_read(4, 1);
      step();
      send_read(4, 2);
      read_data_valid = 1'b1;
      read_data = DATA_W'(16'h0041);
      step();
      idle_inputs();
      vectors++;
      if (outstanding_cnt !== CNT_W'(1) || out_valid !== 1'b1 || out_col !== COL_W'(1) || out_row !== ROW_W'(4)) begin
         miscompares++;
         $display("FAIL same_cycle: cnt=%0d valid=%b row=%0h col=%0h required 1/1/4/1",
                  outstanding_cnt, out_valid, out_row, out_col);
      end
      send_read(4, 3);
      step();
      idle_inputs();
      #2;
      power_on_rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || outstanding_cnt !== '0 || tag_full !== 1'b0 || backend_controller_ren !== 1'b0 ||
          {err_tag_ovf, err_orphan, err_data_ovf} !== 3'b0 || out_col !== '0 || out_row !== '0) begin
         miscompares++;
         $display("FAIL mid_reset: valid=%b cnt=%0d full=%b ren=%b errs=%b row=%0h col=%0h required all 0",
                  out_valid, outstanding_cnt, tag_full, backend_controller_ren,
                  {err_tag_ovf, err_orphan, err_data_ovf}, out_row, out_col);
      end
      @(posedge clk);
      #1;
      power_on_rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cmd_valid       = ($urandom_range(0, 1) == 1);
         cmd_accept      = ($urandom_range(0, 3) != 0);
         cmd_is_read     = ($urandom_range(0, 4) != 0);
         cmd_row         = ROW_W'($urandom);
         cmd_col         = COL_W'($urandom);
         read_data_valid = ($urandom_range(0, 2) == 0);
         read_data       = {32{$urandom}};
         out_ready       = ($urandom_range(0, 9) < 7);
         step();
         vectors++;
         if (outstanding_cnt !== CNT_W'(tag_q.size()) || tag_full !== (tag_q.size() == TAG_DEPTH) ||
             out_valid !== (ret_q.size() > 0) || backend_controller_ren !== m_ren) begin
            miscompares++;
            $display("FAIL rand_ctrl %0d: cnt=%0d full=%b valid=%b ren=%b required %0d/%b/%b/%b", i,
                     outstanding_cnt, tag_full, out_valid, backend_controller_ren,
                     tag_q.size(), (tag_q.size() == TAG_DEPTH), (ret_q.size() > 0), m_ren);
         end
         vectors++;
         if ({err_tag_ovf, err_orphan, err_data_ovf} !== {m_tag_ovf, m_orphan, m_data_ovf}) begin
            miscompares++;
            $display("FAIL rand_err %0d: got %b required %b", i,
                     {err_tag_ovf, err_orphan, err_data_ovf}, {m_tag_ovf, m_orphan, m_data_ovf});
         end
         if (ret_q.size() > 0) begin
            vectors++;
            if (out_data !== ret_q[0].data || out_row !== ret_q[0].row || out_col !== ret_q[0].col) begin
               miscompares++;
               $display("FAIL rand_head %0d: row=%0h col=%0h data=%0h required %0h/%0h/%0h", i,
                        out_row, out_col, out_data[63:0], ret_q[0].row, ret_q[0].col, ret_q[0].data[63:0]);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      power_on_rst = 1'b1;
      out_ready    = 1'b0;
      idle_inputs();
      model_reset();
      test_reset();
      test_in_order();
      test_tag_ovf();
      test_data_ovf();
      test_orphan();
      test_same_cycle_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
